median5_column_buffer: RTL and testbench
========================================

Name: median5_column_buffer

Overview:
- Upstream feeder for the 5x5 median filter's SortAscending5 column sorters.
- Accepts a raster pixel stream, one 8-bit pixel per valid cycle.
- Holds the four previous image rows in line buffers and emits the vertical 5-pixel column (rows y-4..y) at the current x, with a valid strobe.
- Its outputs map 1:1 onto SortAscending5's S1..S5/done_i inputs.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 640: pixels per row; must be ≥ 5.
- IMG_H, 480: rows per frame; must be ≥ 5.
- COL_W, $clog2(IMG_W): column counter width.
- ROW_W, $clog2(IMG_H): row counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  frame-start pulse; clears the position counters.
- done_i  in  1  pixel valid; pixel_i is accepted on a cycle where this is high.
- pixel_i  in  DATA_W  incoming pixel, raster order.
- S1  out  DATA_W  pixel at (x, y-4), the oldest row.
- S2  out  DATA_W  pixel at (x, y-3).
- S3  out  DATA_W  pixel at (x, y-2).
- S4  out  DATA_W  pixel at (x, y-1).
- S5  out  DATA_W  pixel at (x, y), the current pixel.
- done_o  out  1  column valid, one-cycle strobe.
- col_o  out  COL_W  x of the emitted column.
- row_o  out  ROW_W  y of the emitted column.
- frame_done_o  out  1  pulse with the last column of a frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - S1..S5, done_o, col_o, row_o, frame_done_o are cleared to 0.
  - col_cnt and row_cnt are cleared to 0.
  - Line-buffer RAM contents are not cleared.
- Storage:
  - Four line buffers LB0..LB3, each IMG_W x DATA_W.
  - LB0 holds row y-1; LB3 holds row y-4.
- Accepted pixel (done_i=1) at x=col_cnt:
  - Read LBk[x] for k=0..3.
  - Write LB0[x]=pixel_i and LBk[x]=old LB(k-1)[x] for k=1..3; this is a per-column vertical shift.
  - Read is of the old value: read-before-write on the same address.
- Latency:
  - Outputs are registered and appear exactly 1 cycle after acceptance.
  - S1=old LB3[x], S2=old LB2[x], S3=old LB1[x], S4=old LB0[x], S5=pixel_i.
  - col_o and row_o carry the accepted pixel's x and y.
- done_o:
  - Asserts 1 cycle after an accepted pixel with row_cnt ≥ 4.
  - Otherwise 0, including every cycle with done_i=0.
  - No back-pressure: the downstream stage must absorb one column per valid.
- Counters:
  - col_cnt increments on each accepted pixel.
  - At IMG_W-1, col_cnt wraps to 0 and row_cnt increments.
  - At the pixel (IMG_W-1, IMG_H-1), both counters wrap to 0; frame_done_o pulses 1 cycle later, aligned with that column's done_o.
- Idle cycles (done_i=0):
  - Counters, RAM and S1..S5 hold.
  - done_o and frame_done_o are 0.
- start_i:
  - Synchronous clear of col_cnt and row_cnt; RAM is untouched.
  - If start_i and done_i are high in the same cycle, the pixel is accepted as (0,0) and the counters then advance to col 1.
  - start_i mid-frame aborts the frame: no frame_done_o is issued, and stale rows are masked because rows 0..3 produce no done_o.
- Reset mid-frame: same as start_i, plus all outputs are cleared immediately.

Optional Feature:
- Macro: MEDIAN5_BORDER_REPLICATE_EN.
- When defined:
  - done_o also asserts for rows 0..3.
  - Rows above the image are replaced by the nearest valid row: for row_cnt=r<4, any S(k) referring to row y-j with j>r takes the value of the row-0 pixel, which is stored in LB(r-1), or pixel_i itself when r=0.
  - The result is one output column per input pixel, IMG_W*IMG_H per frame.
- When undefined: rows 0..3 are suppressed, giving IMG_W*(IMG_H-4) columns per frame.

Decomposition:
- Shared package median_pkg:
  - DATA_W default.
  - Typedef for the pixel word.
  - Typedef for the 5-pixel column bundle, shared with SortAscending5.
  - Constant WIN_SIZE=5.
- Sub-module median5_line_ram:
  - Single-clock RAM, IMG_W x DATA_W.
  - Synchronous read-before-write, read and write on the same address.
  - Instantiated 4 times.

Test Plan (IMG_W=8, IMG_H=8, pixel value = 16*y + x):
1. Reset → rst_n=0 mid-stream → all outputs 0 immediately; the next pixel after release is accepted at (0,0).
2. Stream 64 continuous pixels → done_o is first high 1 cycle after pixel (0,4) with S1..S5 = 0x00, 0x10, 0x20, 0x30, 0x40; exactly 32 done_o pulses in total.
3. Pixel (2,4) → S1..S5 = 0x02, 0x12, 0x22, 0x32, 0x42; col_o=2, row_o=4.
4. Same frame with done_i toggled 1,0,0,1,… → identical output values; done_o only follows accepted pixels; outputs hold during gaps.
5. Last pixel (7,7) → frame_done_o=1 together with done_o, S1..S5 = 0x37, 0x47, 0x57, 0x67, 0x77; the next frame restarts at (0,0) with no done_o for rows 0..3.
6. start_i asserted together with done_i at pixel 20 → that pixel is taken as (0,0), no frame_done_o is issued for the aborted frame, and the first done_o follows the 33rd pixel after start.
7. With MEDIAN5_BORDER_REPLICATE_EN defined → pixel (3,1) gives S1..S5 = 0x03, 0x03, 0x03, 0x03, 0x13, and 64 done_o pulses per frame.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types for the 5x5 median filter datapath.
// Pixel word, 5-pixel column bundle, window size.
package median_pkg;

   localparam int DATA_W   = 8;
   localparam int WIN_SIZE = 5;

   typedef logic [DATA_W-1:0] pix_t;
   typedef pix_t [WIN_SIZE-1:0] col_t;

endpackage

// File: rtl/median5_line_ram.sv
// One image row of pixel storage, single clock, one shared address.
// rd_old is the pre-write word that feeds the next buffer in the shift chain.
module median5_line_ram
   import median_pkg::*;
#(
   parameter int DATA_W = median_pkg::DATA_W,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rd_old,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_old = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (en) rdata <= rd_old;
   end

endmodule

// File: rtl/median5_column_buffer.sv
// Four-row line buffer emitting the 5-pixel column at the current x.
// Define MEDIAN5_BORDER_REPLICATE_EN to emit rows 0..3 with top-row replication.
module median5_column_buffer
   import median_pkg::*;
#(
   parameter int DATA_W = median_pkg::DATA_W,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int COL_W  = $clog2(IMG_W),
   parameter int ROW_W  = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              done_i,
   input  logic [DATA_W-1:0] pixel_i,
   output logic [DATA_W-1:0] S1,
   output logic [DATA_W-1:0] S2,
   output logic [DATA_W-1:0] S3,
   output logic [DATA_W-1:0] S4,
   output logic [DATA_W-1:0] S5,
   output logic              done_o,
   output logic [COL_W-1:0]  col_o,
   output logic [ROW_W-1:0]  row_o,
   output logic              frame_done_o
);

   localparam int NLB = WIN_SIZE - 1;

   logic [COL_W-1:0]  col_cnt, x;
   logic [ROW_W-1:0]  row_cnt, y;
   logic              last_col, last_row, show;
   logic [DATA_W-1:0] wd     [NLB];
   logic [DATA_W-1:0] rd_old [NLB];
   logic [DATA_W-1:0] rdq    [NLB];
   logic [DATA_W-1:0] s5_q;
   logic [DATA_W-1:0] c      [WIN_SIZE];
   logic [DATA_W-1:0] s      [WIN_SIZE];

   // start_i re-bases the pixel accepted in the same cycle to (0,0)
   assign x        = start_i ? '0 : col_cnt;
   assign y        = start_i ? '0 : row_cnt;
   assign last_col = (x == COL_W'(IMG_W - 1));
   assign last_row = (y == ROW_W'(IMG_H - 1));

`ifdef MEDIAN5_BORDER_REPLICATE_EN
   assign show = 1'b1;
`else
   assign show = (y >= ROW_W'(NLB));
`endif

   always_comb begin
      wd[0] = pixel_i;
      for (int k = 1; k < NLB; k++)
         wd[k] = rd_old[k-1];
   end

   for (genvar k = 0; k < NLB; k++) begin : g_lb
      median5_line_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (IMG_W),
         .ADDR_W (COL_W)
      ) u_lb (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (done_i),
         .addr   (x),
         .wdata  (wd[k]),
         .rd_old (rd_old[k]),
         .rdata  (rdq[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt      <= '0;
         row_cnt      <= '0;
         s5_q         <= '0;
         col_o        <= '0;
         row_o        <= '0;
         done_o       <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         done_o       <= 1'b0;
         frame_done_o <= 1'b0;
         if (done_i) begin
            s5_q         <= pixel_i;
            col_o        <= x;
            row_o        <= y;
            done_o       <= show;
            frame_done_o <= last_col && last_row;
            if (last_col) begin
               col_cnt <= '0;
               row_cnt <= last_row ? '0 : y + 1'b1;
            end else begin
               col_cnt <= x + 1'b1;
               row_cnt <= y;
            end
         end else if (start_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end
      end
   end

   always_comb begin
      c[0] = rdq[3];
      c[1] = rdq[2];
      c[2] = rdq[1];
      c[3] = rdq[0];
      c[4] = s5_q;
   end

`ifdef MEDIAN5_BORDER_REPLICATE_EN
   // Rows above the image take the row-0 pixel, held at c[NLB - row]
   always_comb begin
      for (int k = 0; k < WIN_SIZE; k++) begin
         s[k] = c[k];
         if (int'(row_o) < NLB && (NLB - k) > int'(row_o))
            s[k] = c[NLB - int'(row_o)];
      end
   end
`else
   always_comb begin
      for (int k = 0; k < WIN_SIZE; k++)
         s[k] = c[k];
   end
`endif

   assign S1 = s[0];
   assign S2 = s[1];
   assign S3 = s[2];
   assign S4 = s[3];
   assign S5 = s[4];

endmodule

// File: tb/tb_median5_column_buffer.sv
// Directed bench for median5_column_buffer on an 8x8 frame.
// Pixel value is 16*y + x; expected columns derive from that.
module tb_median5_column_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       done_i;
   logic [7:0] pixel_i;
   logic [7:0] S1, S2, S3, S4, S5;
   logic       done_o;
   logic [2:0] col_o;
   logic [2:0] row_o;
   logic       frame_done_o;

   int n_chk  = 0;
   int n_pass = 0;
   int pulses;
   int fdones;
   int first_done;

   median5_column_buffer #(
      .DATA_W (8),
      .IMG_W  (8),
      .IMG_H  (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .done_i       (done_i),
      .pixel_i      (pixel_i),
      .S1           (S1),
      .S2           (S2),
      .S3           (S3),
      .S4           (S4),
      .S5           (S5),
      .done_o       (done_o),
      .col_o        (col_o),
      .row_o        (row_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk = ~clk;

`ifdef MEDIAN5_BORDER_REPLICATE_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   function automatic logic [31:0] ev(input int x, input int y, input int j);
      int ry;
      ry = y - j;
      if (ry < 0) ry = 0;
      return 32'(16 * ry + x);
   endfunction

   function automatic logic exp_done(input int y);
      return BORDER || (y >= 4);
   endfunction

   task automatic step(input logic v, input logic [7:0] p, input logic st);
      @(negedge clk);
      done_i  = v;
      pixel_i = p;
      start_i = st;
      @(posedge clk);
      #1;
   endtask

   task automatic check_pix(input int x, input int y);
      check("col", 32'(col_o), 32'(x));
      check("row", 32'(row_o), 32'(y));
      check("done", 32'(done_o), 32'(exp_done(y)));
      check("fdone", 32'(frame_done_o), 32'(x == 7 && y == 7));
      if (done_o) pulses++;
      if (frame_done_o) fdones++;
      if (exp_done(y)) begin
         check("S1", 32'(S1), ev(x, y, 4));
         check("S2", 32'(S2), ev(x, y, 3));
         check("S3", 32'(S3), ev(x, y, 2));
         check("S4", 32'(S4), ev(x, y, 1));
         check("S5", 32'(S5), ev(x, y, 0));
      end
   endtask

   task automatic run_frame(input int gap);
      logic [7:0] h [5];
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 8'(16 * (i / 8) + i % 8), 1'b0);
         check_pix(i % 8, i / 8);
         h[0] = S1; h[1] = S2; h[2] = S3; h[3] = S4; h[4] = S5;
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 8'hEE, 1'b0);
            check("idle_done", 32'(done_o), 32'd0);
            check("idle_fdone", 32'(frame_done_o), 32'd0);
            check("hold", {S1, S2, S3, S4}, {h[0], h[1], h[2], h[3]});
            check("hold5", 32'(S5), 32'(h[4]));
         end
      end
      check("pulses", 32'(pulses), BORDER ? 32'd64 : 32'd32);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_i = 1'b0;
      done_i  = 1'b0;
      pixel_i = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_S", {S1, S2, S3, S4}, 32'd0);
      check("rst_pos", {col_o, row_o, frame_done_o, S5}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         step(1'b1, 8'h55, 1'b0);
      check("pre_col", 32'(col_o), 32'd1);
      @(negedge clk);
      done_i = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mid_rst_S5", 32'(S5), 32'd0);
      check("mid_rst_col", 32'(col_o), 32'd0);
      check("mid_rst_row", 32'(row_o), 32'd0);
      check("mid_rst_done", {done_o, frame_done_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      fdones = 0;
      run_frame(0);
      check("f1_fdones", 32'(fdones), 32'd1);

      fdones = 0;
      run_frame(2);
      check("f2_fdones", 32'(fdones), 32'd1);

      fdones = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'(8'hA0 + i), 1'b0);
         check("abort_fdone", 32'(frame_done_o), 32'd0);
      end
      pulses     = 0;
      first_done = -1;
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 8'(16 * (i / 8) + i % 8), i == 0);
         check_pix(i % 8, i / 8);
         if (done_o && first_done < 0) first_done = i + 1;
      end
      check("first_done", 32'(first_done), BORDER ? 32'd1 : 32'd33);
      check("f3_fdones", 32'(fdones), 32'd1);
      check("f3_pulses", 32'(pulses), BORDER ? 32'd64 : 32'd32);

      step(1'b0, 8'h00, 1'b0);
      check("end_done", 32'(done_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
